// File: rtl/merge_run_feeder_if.sv
// Bundles the upstream element stream and the merger-facing FWFT read port of
// one merge_run_feeder instance.
interface merge_run_feeder_if #(
  parameter int DATA_WIDTH = 128,
  parameter int LANES      = 32
);
  logic [DATA_WIDTH-1:0]       i_elem;
  logic                        i_elem_valid;
  logic                        i_elem_last;
  logic                        o_elem_ready;
  logic [LANES*DATA_WIDTH-1:0] o_fifo_data;
  logic                        o_fifo_empty;
  logic                        i_fifo_read;

  // Environment side: upstream producer plus merger read port.
  modport master (
    output i_elem, i_elem_valid, i_elem_last, i_fifo_read,
    input  o_elem_ready, o_fifo_data, o_fifo_empty
  );

  // Feeder side.
  modport slave (
    input  i_elem, i_elem_valid, i_elem_last, i_fifo_read,
    output o_elem_ready, o_fifo_data, o_fifo_empty
  );
endinterface

// File: rtl/merge_run_feeder.sv
// Packs a sorted element stream into LANES-wide words, closes every run with an
// all-zero terminator word and presents the words through a small FWFT queue.
module merge_run_feeder #(
  parameter int                    DATA_WIDTH = 128,
  parameter int                    KEY_WIDTH  = 80,
  parameter int                    LANES      = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = {DATA_WIDTH{1'b1}}
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  merge_run_feeder_if.slave        port_if,
  output logic [31:0]              o_word_count,
  output logic                     o_underrun,
  output logic                     o_zero_err
);

  localparam int WORD_W = LANES * DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  generate
    if (KEY_WIDTH < 1 || KEY_WIDTH > DATA_WIDTH) begin : g_bad_key_width
      $error("merge_run_feeder: KEY_WIDTH must lie in 1..DATA_WIDTH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("merge_run_feeder: DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    FILL = 1'b0,
    TERM = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         word_count_q, word_count_d;
  logic                underrun_q, underrun_d;
  logic                zero_err_q, zero_err_d;

  logic                elem_ready;
  logic                accept;
  logic                push;
  logic                pop;
  logic [WORD_W-1:0]   push_word;
  wire  [WORD_W-1:0]   fill_word;

  // Candidate word after writing i_elem into the current lane; when the
  // element closes the run, every later lane takes the pad value.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [LANE_W-1:0] GI = LANE_W'(gi);
    assign fill_word[gi*DATA_WIDTH +: DATA_WIDTH] =
        (lane_q == GI)                             ? port_if.i_elem :
        (port_if.i_elem_last && (lane_q < GI))     ? PAD_VALUE      :
                                                     asm_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    elem_ready = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    push_word  = '0;
    unique case (state_q)
      FILL: begin
        elem_ready = (count_q < DEPTH_C);
        accept     = elem_ready && port_if.i_elem_valid;
        if (accept) begin
          if (port_if.i_elem_last || (lane_q == LAST_LANE)) begin
            push      = 1'b1;
            push_word = fill_word;
            lane_d    = '0;
            asm_d     = '0;
            if (port_if.i_elem_last) begin
              state_d = TERM;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
            asm_d  = fill_word;
          end
        end
      end
      TERM: begin
        // push_word stays all-zero: the terminator the merger looks for.
        if (count_q < DEPTH_C) begin
          push    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    pop          = port_if.i_fifo_read && (count_q != '0);
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    word_count_d = word_count_q + 32'(push);
    underrun_d   = underrun_q || (port_if.i_fifo_read && (count_q == '0));
    zero_err_d   = zero_err_q || (accept && (port_if.i_elem == '0));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= FILL;
      lane_q       <= '0;
      asm_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      word_count_q <= '0;
      underrun_q   <= 1'b0;
      zero_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      word_count_q <= word_count_d;
      underrun_q   <= underrun_d;
      zero_err_q   <= zero_err_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign port_if.o_elem_ready = elem_ready;
  assign port_if.o_fifo_empty = (count_q == '0);
  assign port_if.o_fifo_data  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign o_word_count         = word_count_q;
  assign o_underrun           = underrun_q;
  assign o_zero_err           = zero_err_q;

endmodule

// File: tb/tb_merge_run_feeder.sv
// Randomized bench for merge_run_feeder: runs are turned into expected wide words
// by a simple chunk-and-pad model and compared against every word popped.
module tb_merge_run_feeder;

  localparam int DW = 16;
  localparam int KW = 8;
  localparam int LN = 4;
  localparam int DP = 4;
  localparam int WW = DW * LN;
  localparam logic [DW-1:0] PAD = {DW{1'b1}};

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } elem_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word_count;
  logic        underrun;
  logic        zero_err;

  merge_run_feeder_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

  merge_run_feeder #(
    .DATA_WIDTH(DW),
    .KEY_WIDTH (KW),
    .LANES     (LN),
    .DEPTH     (DP)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .port_if     (bus.slave),
    .o_word_count(word_count),
    .o_underrun  (underrun),
    .o_zero_err  (zero_err)
  );

  always #5 clk = ~clk;

  int            tests_run    = 0;
  int            tests_failed = 0;
  elem_t         stim_q[$];
  logic [WW-1:0] exp_q[$];
  int            exp_wc    = 0;
  int            ready_low = 0;
  int            wc_base   = 0;
  logic [DW-1:0] run_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: chunk the run into LN-element words, pad the tail, add a terminator.
  task automatic add_run(input logic [DW-1:0] elems[$]);
    int            n;
    int            nw;
    elem_t         e;
    logic [WW-1:0] word;
    n  = elems.size();
    nw = (n + LN - 1) / LN;
    for (int i = 0; i < n; i++) begin
      e.data = elems[i];
      e.last = (i == n - 1);
      stim_q.push_back(e);
    end
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int l = 0; l < LN; l++) begin
        word[l*DW +: DW] = (w * LN + l < n) ? elems[w * LN + l] : PAD;
      end
      exp_q.push_back(word);
    end
    exp_q.push_back('0);
    exp_wc += nw + 1;
    $display("[TB] run of %0d elements queued, %0d words expected", n, nw + 1);
  endtask

  task automatic add_seq(input int start, input int n);
    logic [DW-1:0] q[$];
    for (int i = 0; i < n; i++) q.push_back(DW'(start + i));
    add_run(q);
  endtask

  // Called at a negedge: present the next stimulus element, retire it if accepted.
  task automatic drive_elem(input int vld_pct);
    bit v;
    v = (stim_q.size() > 0) && ($urandom_range(99) < vld_pct);
    bus.i_elem_valid = v;
    bus.i_elem       = v ? stim_q[0].data : '0;
    bus.i_elem_last  = v ? stim_q[0].last : 1'b0;
    if (v && bus.o_elem_ready) void'(stim_q.pop_front());
  endtask

  // Called at a negedge: optionally pop the head and compare it to the model.
  task automatic drive_read(input int rd_pct);
    bit r;
    r = !bus.o_fifo_empty && ($urandom_range(99) < rd_pct);
    bus.i_fifo_read = r;
    if (bus.o_fifo_empty) check("empty_data_zero", 64'(bus.o_fifo_data), 64'd0);
    if (r) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("word_data", 64'(bus.o_fifo_data), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic stream(input int vld_pct, input int rd_pct, input int max_cycles);
    int cyc;
    cyc       = 0;
    ready_low = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      if (!bus.o_elem_ready) ready_low++;
      drive_elem(vld_pct);
      drive_read(rd_pct);
    end
    check("stream_done", 64'(stim_q.size() + exp_q.size()), 64'd0);
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_n            = 1'b0;
    bus.i_elem_valid = 1'b0;
    bus.i_elem_last  = 1'b0;
    bus.i_elem       = '0;
    bus.i_fifo_read  = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    stim_q.delete();
    exp_q.delete();
    exp_wc = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_empty"},      64'(bus.o_fifo_empty), 64'd1);
    check({tag, "_data"},       64'(bus.o_fifo_data),  64'd0);
    check({tag, "_ready"},      64'(bus.o_elem_ready), 64'd1);
    check({tag, "_word_count"}, 64'(word_count),       64'd0);
    check({tag, "_underrun"},   64'(underrun),         64'd0);
    check({tag, "_zero_err"},   64'(zero_err),         64'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_elem       = '0;
    bus.i_elem_valid = 1'b0;
    bus.i_elem_last  = 1'b0;
    bus.i_fifo_read  = 1'b0;

    // Reset state.
    apply_reset(3);
    @(negedge clk);
    check_idle("t1");

    // Two full words plus terminator, consumer always reading.
    add_seq(1, 8);
    stream(100, 100, 200);
    check("t2_ready_low_cycles", 64'(ready_low), 64'd1);
    check("t2_word_count", 64'(word_count), 64'(exp_wc));

    // Partial final word gets padded.
    add_seq(5, 2);
    stream(100, 100, 200);
    check("t3_word_count", 64'(word_count), 64'(exp_wc));

    // Stalled consumer: the queue fills after four words, one read reopens it.
    wc_base = exp_wc;
    add_seq(16'h0100, 20);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      drive_elem(100);
      bus.i_fifo_read = 1'b0;
    end
    check("t4_accepted_left", 64'(stim_q.size()), 64'd4);
    @(negedge clk);
    check("t4_ready_full", 64'(bus.o_elem_ready), 64'd0);
    check("t4_not_empty", 64'(bus.o_fifo_empty), 64'd0);
    check("t4_word_count_full", 64'(word_count), 64'(wc_base + 4));
    drive_elem(100);
    drive_read(100);
    @(negedge clk);
    check("t4_ready_resume", 64'(bus.o_elem_ready), 64'd1);
    drive_elem(100);
    drive_read(0);
    stream(100, 60, 500);
    check("t4_word_count_final", 64'(word_count), 64'(exp_wc));

    // Read while empty: sticky underrun, queue untouched.
    @(negedge clk);
    check("t5_empty_before", 64'(bus.o_fifo_empty), 64'd1);
    check("t5_underrun_before", 64'(underrun), 64'd0);
    drive_elem(0);
    bus.i_fifo_read = 1'b1;
    @(negedge clk);
    bus.i_fifo_read = 1'b0;
    check("t5_underrun_set", 64'(underrun), 64'd1);
    check("t5_still_empty", 64'(bus.o_fifo_empty), 64'd1);
    repeat (3) @(negedge clk);
    check("t5_underrun_sticky", 64'(underrun), 64'd1);
    check("t5_word_count", 64'(word_count), 64'(exp_wc));

    // An all-zero element is flagged and still packed.
    check("t5_zero_err_before", 64'(zero_err), 64'd0);
    run_q.delete();
    run_q.push_back(DW'(3));
    run_q.push_back(DW'(0));
    run_q.push_back(DW'(7));
    add_run(run_q);
    stream(100, 100, 200);
    check("t5_zero_err_set", 64'(zero_err), 64'd1);

    // Reset mid-word discards the partial word and realigns lanes.
    stim_q.delete();
    stim_q.push_back('{data: DW'(16'h00A1), last: 1'b0});
    stim_q.push_back('{data: DW'(16'h00A2), last: 1'b0});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive_elem(100);
      drive_read(0);
    end
    check("t6_partial_accepted", 64'(stim_q.size()), 64'd0);
    apply_reset(2);
    @(negedge clk);
    check_idle("t6");
    add_seq(9, 4);
    stream(100, 100, 200);
    check("t6_word_count", 64'(word_count), 64'(exp_wc));

    // Random runs under random producer/consumer throttling.
    for (int round = 0; round < 3; round++) begin
      for (int r = 0; r < 4; r++) begin
        int len;
        len = int'($urandom_range(1, 13));
        run_q.delete();
        for (int i = 0; i < len; i++) run_q.push_back(DW'($urandom_range(1, 16'hFFFF)));
        add_run(run_q);
      end
      stream(int'($urandom_range(40, 100)), int'($urandom_range(20, 100)), 2000);
      check("rand_word_count", 64'(word_count), 64'(exp_wc));
    end
    check("rand_underrun", 64'(underrun), 64'd0);
    check("rand_zero_err", 64'(zero_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
